// File: rtl/debug_unlock_ctrl.sv
// Debug unlock controller: two-word key over valid/ready opens a timed session,
// repeated failures latch a permanent lockout, scan_mode always forces locked.
module debug_unlock_ctrl #(
  parameter logic [15:0] KEY0          = 16'hA5C3,
  parameter logic [15:0] KEY1          = 16'h3C5A,
  parameter int unsigned MAX_ATTEMPTS  = 3,
  parameter int unsigned UNLOCK_CYCLES = 1024,
  parameter int unsigned KEY_TIMEOUT   = 64
) (
  input  logic        Clk,
  input  logic        resetn,
  input  logic        debug_req,
  input  logic        key_valid,
  input  logic [15:0] key_data,
  output logic        key_ready,
  input  logic        debug_relock,
  input  logic        scan_mode,
  output logic        debug_unlocked,
  output logic        lockout,
  output logic [3:0]  fail_count,
  output logic        attempt_done,
  output logic        attempt_pass
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_K0  = 3'd1,
    WAIT_K1  = 3'd2,
    UNLOCKED = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  localparam int SES_W = $clog2(UNLOCK_CYCLES + 1);
  localparam int TO_W  = $clog2(KEY_TIMEOUT + 1);

  localparam logic [SES_W-1:0] SES_LOAD = SES_W'(UNLOCK_CYCLES);
  localparam logic [SES_W-1:0] SES_ONE  = SES_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(KEY_TIMEOUT - 1);
  localparam logic [3:0]       MAX_A    = 4'(MAX_ATTEMPTS);

  state_t            state;
  logic              match0;
  logic [TO_W-1:0]   timeout_cnt;
  logic [SES_W-1:0]  session_cnt;

  logic              xfer;
  logic              resolve;
  logic              resolve_pass;
  logic [3:0]        fail_next;

  // scan_mode gates ready combinationally so a same-cycle transfer can never land
  assign key_ready    = ((state == WAIT_K0) || (state == WAIT_K1)) && !scan_mode;
  assign xfer         = key_valid && key_ready;
  assign resolve      = (state == WAIT_K1) && !scan_mode && (xfer || (timeout_cnt == TO_LAST));
  assign resolve_pass = xfer && match0 && (key_data == KEY1);
  assign fail_next    = (fail_count == 4'hF) ? 4'hF : fail_count + 4'd1;

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      match0         <= 1'b0;
      timeout_cnt    <= '0;
      session_cnt    <= '0;
      debug_unlocked <= 1'b0;
      lockout        <= 1'b0;
      fail_count     <= 4'd0;
      attempt_done   <= 1'b0;
      attempt_pass   <= 1'b0;
    end else begin
      attempt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (debug_req && !scan_mode)
            state <= WAIT_K0;
        end

        WAIT_K0: begin
          if (scan_mode) begin
            state <= IDLE;
          end else if (xfer) begin
            match0      <= (key_data == KEY0);
            timeout_cnt <= '0;
            state       <= WAIT_K1;
          end
        end

        WAIT_K1: begin
          if (scan_mode) begin
            state <= IDLE;
          end else if (resolve) begin
            attempt_done <= 1'b1;
            attempt_pass <= resolve_pass;
            timeout_cnt  <= '0;
            if (resolve_pass) begin
              state          <= UNLOCKED;
              debug_unlocked <= 1'b1;
              session_cnt    <= SES_LOAD;
            end else begin
              fail_count <= fail_next;
              if (fail_next >= MAX_A) begin
                state   <= LOCKOUT;
                lockout <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end

        UNLOCKED: begin
          // exiting on a count of one gives exactly UNLOCK_CYCLES unlocked cycles
          if (scan_mode || debug_relock || (session_cnt == SES_ONE)) begin
            state          <= IDLE;
            debug_unlocked <= 1'b0;
            session_cnt    <= '0;
          end else begin
            session_cnt <= session_cnt - 1'b1;
          end
        end

        LOCKOUT: begin
          state          <= LOCKOUT;
          lockout        <= 1'b1;
          debug_unlocked <= 1'b0;
        end

        default: begin
          state          <= IDLE;
          debug_unlocked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_unlock_ctrl.sv
// Directed bench for debug_unlock_ctrl with a short session, short timeout and
// three-attempt lockout.
module tb_debug_unlock_ctrl;

  logic        Clk = 1'b0;
  logic        resetn = 1'b0;
  logic        debug_req = 1'b0;
  logic        key_valid = 1'b0;
  logic [15:0] key_data = 16'h0000;
  logic        key_ready;
  logic        debug_relock = 1'b0;
  logic        scan_mode = 1'b0;
  logic        debug_unlocked;
  logic        lockout;
  logic [3:0]  fail_count;
  logic        attempt_done;
  logic        attempt_pass;

  int errors = 0;
  int checks = 0;

  debug_unlock_ctrl #(
    .KEY0(16'hA5C3),
    .KEY1(16'h3C5A),
    .MAX_ATTEMPTS(3),
    .UNLOCK_CYCLES(16),
    .KEY_TIMEOUT(8)
  ) dut (
    .Clk(Clk),
    .resetn(resetn),
    .debug_req(debug_req),
    .key_valid(key_valid),
    .key_data(key_data),
    .key_ready(key_ready),
    .debug_relock(debug_relock),
    .scan_mode(scan_mode),
    .debug_unlocked(debug_unlocked),
    .lockout(lockout),
    .fail_count(fail_count),
    .attempt_done(attempt_done),
    .attempt_pass(attempt_pass)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_attempt(input logic [15:0] k0, input logic [15:0] k1);
    debug_req = 1'b1;
    step();
    debug_req = 1'b0;
    key_valid = 1'b1;
    key_data  = k0;
    step();
    key_data  = k1;
    step();
    key_valid = 1'b0;
  endtask

  initial begin
    // reset values
    #12;
    chk("rst_unlocked", debug_unlocked, 1'b0);
    chk("rst_lockout", lockout, 1'b0);
    chk("rst_fail", fail_count, 4'd0);
    chk("rst_ready", key_ready, 1'b0);
    chk("rst_done", attempt_done, 1'b0);
    chk("rst_pass", attempt_pass, 1'b0);
    resetn = 1'b1;
    step();
    $display("reset checked");

    // correct unlock with handshake observed in both wait states
    debug_req = 1'b1;
    step();
    debug_req = 1'b0;
    chk("k0_ready", key_ready, 1'b1);
    key_valid = 1'b1;
    key_data  = 16'hA5C3;
    step();
    chk("k1_ready", key_ready, 1'b1);
    chk("k1_no_done", attempt_done, 1'b0);
    key_data = 16'h3C5A;
    step();
    key_valid = 1'b0;
    chk("pass_unlocked", debug_unlocked, 1'b1);
    chk("pass_done", attempt_done, 1'b1);
    chk("pass_pass", attempt_pass, 1'b1);
    chk("pass_ready_low", key_ready, 1'b0);
    $display("unlock attempt: unlocked=%0b pass=%0b", debug_unlocked, attempt_pass);

    // session length: 16 cycles high, then auto relock
    for (int i = 2; i <= 16; i++) begin
      step();
      if (i == 2) chk("done_one_cycle", attempt_done, 1'b0);
      chk($sformatf("session_c%0d", i), debug_unlocked, 1'b1);
    end
    step();
    chk("session_expired", debug_unlocked, 1'b0);
    chk("pass_held", attempt_pass, 1'b1);
    $display("session expiry: unlocked=%0b", debug_unlocked);

    // second unlock, then software relock
    do_attempt(16'hA5C3, 16'h3C5A);
    chk("reunlock", debug_unlocked, 1'b1);
    step();
    debug_relock = 1'b1;
    step();
    debug_relock = 1'b0;
    chk("relock", debug_unlocked, 1'b0);
    chk("relock_fail0", fail_count, 4'd0);
    $display("relock: unlocked=%0b", debug_unlocked);

    // scan_mode for one cycle ends the session
    do_attempt(16'hA5C3, 16'h3C5A);
    chk("scan_pre", debug_unlocked, 1'b1);
    scan_mode = 1'b1;
    step();
    scan_mode = 1'b0;
    chk("scan_relock", debug_unlocked, 1'b0);
    $display("scan in session: unlocked=%0b", debug_unlocked);

    // scan_mode in WAIT_K1 blocks the transfer and aborts silently
    debug_req = 1'b1;
    step();
    debug_req = 1'b0;
    key_valid = 1'b1;
    key_data  = 16'hA5C3;
    step();
    scan_mode = 1'b1;
    key_data  = 16'h3C5A;
    #1;
    chk("scan_ready_low", key_ready, 1'b0);
    step();
    chk("scan_abort_done", attempt_done, 1'b0);
    chk("scan_abort_unlk", debug_unlocked, 1'b0);
    chk("scan_abort_fail", fail_count, 4'd0);
    scan_mode = 1'b0;
    #1;
    chk("scan_abort_idle", key_ready, 1'b0);
    key_valid = 1'b0;
    step();
    $display("scan in WAIT_K1: done=%0b fail=%0d", attempt_done, fail_count);

    // second word timeout after 8 idle cycles
    debug_req = 1'b1;
    step();
    debug_req = 1'b0;
    key_valid = 1'b1;
    key_data  = 16'hA5C3;
    step();
    key_valid = 1'b0;
    for (int i = 1; i <= 7; i++) step();
    chk("to_not_yet", attempt_done, 1'b0);
    step();
    chk("to_done", attempt_done, 1'b1);
    chk("to_pass", attempt_pass, 1'b0);
    chk("to_fail", fail_count, 4'd1);
    chk("to_idle", key_ready, 1'b0);
    step();
    chk("to_done_clr", attempt_done, 1'b0);
    $display("timeout: fail=%0d", fail_count);

    // unlock keeps fail_count; async reset mid-session with relock
    do_attempt(16'hA5C3, 16'h3C5A);
    chk("keep_fail", fail_count, 4'd1);
    chk("pre_reset_unlk", debug_unlocked, 1'b1);
    debug_relock = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    chk("async_unlk", debug_unlocked, 1'b0);
    chk("async_fail", fail_count, 4'd0);
    chk("async_lockout", lockout, 1'b0);
    #1;
    debug_relock = 1'b0;
    resetn = 1'b1;
    step();
    $display("async reset: unlocked=%0b fail=%0d", debug_unlocked, fail_count);

    // three wrong attempts lead to lockout
    for (int a = 1; a <= 3; a++) begin
      debug_req = 1'b1;
      step();
      debug_req = 1'b0;
      key_valid = 1'b1;
      key_data  = 16'h0000;
      step();
      chk($sformatf("bad%0d_k1_ready", a), key_ready, 1'b1);
      chk($sformatf("bad%0d_no_done", a), attempt_done, 1'b0);
      key_data = 16'h3C5A;
      step();
      key_valid = 1'b0;
      chk($sformatf("bad%0d_done", a), attempt_done, 1'b1);
      chk($sformatf("bad%0d_pass", a), attempt_pass, 1'b0);
      chk($sformatf("bad%0d_fail", a), fail_count, 4'(a));
      chk($sformatf("bad%0d_lockout", a), lockout, (a == 3) ? 1'b1 : 1'b0);
      $display("bad attempt %0d: fail=%0d lockout=%0b", a, fail_count, lockout);
    end

    // lockout ignores further correct attempts
    debug_req = 1'b1;
    step();
    debug_req = 1'b0;
    chk("lock_ready", key_ready, 1'b0);
    key_valid = 1'b1;
    key_data  = 16'hA5C3;
    step();
    key_data = 16'h3C5A;
    step();
    key_valid = 1'b0;
    step();
    chk("lock_unlk", debug_unlocked, 1'b0);
    chk("lock_sticky", lockout, 1'b1);
    chk("lock_fail", fail_count, 4'd3);
    chk("lock_ready2", key_ready, 1'b0);
    $display("lockout hold: lockout=%0b", lockout);

    // only reset clears lockout
    #2;
    resetn = 1'b0;
    #1;
    chk("clr_lockout", lockout, 1'b0);
    chk("clr_fail", fail_count, 4'd0);
    resetn = 1'b1;
    step();
    do_attempt(16'hA5C3, 16'h3C5A);
    chk("after_clr_unlk", debug_unlocked, 1'b1);
    $display("lockout cleared: unlocked=%0b", debug_unlocked);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_unlock_ctrl.md
Name: debug_unlock_ctrl

Overview:
Generates the debug_unlocked qualifier consumed by the team's lockable configuration registers. Debug software supplies a two-word key over a valid/ready port. A correct key opens a time-limited unlock session. Repeated failures cause a permanent lockout, and scan_mode can never open or hold a session.

Parameters:
KEY0, 16'hA5C3, first key word
KEY1, 16'h3C5A, second key word
MAX_ATTEMPTS, 3, failed attempts before permanent lockout (1..15)
UNLOCK_CYCLES, 1024, session length in Clk cycles before auto-relock (>=2)
KEY_TIMEOUT, 64, max cycles allowed between the two key words (>=2)

Ports:
Clk  input  1  clock
resetn  input  1  reset, asynchronous, active-low
debug_req  input  1  one-cycle pulse; starts an unlock attempt
key_valid  input  1  key word valid
key_data  input  16  key word
key_ready  output  1  controller accepts a key word this cycle
debug_relock  input  1  software request to end the session
scan_mode  input  1  scan active; forces the locked state
debug_unlocked  output  1  unlock session active
lockout  output  1  permanent lockout reached (sticky until reset)
fail_count  output  4  failed attempts so far, saturating
attempt_done  output  1  one-cycle pulse when an attempt resolves
attempt_pass  output  1  result of the last attempt; valid with attempt_done, held afterwards

Behaviour:
- Clocking: all state is on the posedge of Clk. Async reset is on the negedge of resetn.
- Reset values:
  - state=IDLE
  - debug_unlocked=0, lockout=0, fail_count=0
  - key_ready=0, attempt_done=0, attempt_pass=0
  - all counters 0
- States: IDLE, WAIT_K0, WAIT_K1, UNLOCKED, LOCKOUT.
- Handshake: a key word transfers only when key_valid and key_ready are both 1 in the same cycle.
  - key_ready=1 only in WAIT_K0 and WAIT_K1, and only when scan_mode=0.
  - key_valid without key_ready is ignored.
- IDLE:
  - debug_req=1 and scan_mode=0 -> WAIT_K0.
  - debug_req in any other state is ignored.
- WAIT_K0:
  - On a transfer, store match0 = (key_data==KEY0) and go to WAIT_K1. Clear the timeout counter.
  - WAIT_K0 has no timeout.
- WAIT_K1:
  - The timeout counter increments every cycle with no transfer.
  - Transfer -> resolve the attempt: pass = match0 && (key_data==KEY1).
  - Both words are always collected; a wrong first word never aborts early.
  - Counter reaching KEY_TIMEOUT with no transfer -> resolve the attempt as a fail.
- Resolve, registered with a single-cycle effect:
  - attempt_done=1 for one cycle and attempt_pass=pass.
  - Pass -> UNLOCKED. debug_unlocked=1 from the cycle after the KEY1 transfer edge. Load the session counter with UNLOCK_CYCLES. fail_count is not cleared.
  - Fail -> fail_count+1, saturating at 15.
    - If the new fail_count >= MAX_ATTEMPTS, go to LOCKOUT and set lockout=1.
    - Otherwise go to IDLE.
- UNLOCKED:
  - The session counter decrements every cycle.
  - Any of the following -> IDLE with debug_unlocked=0 on the next cycle:
    - counter reaches 0 (session lasts exactly UNLOCK_CYCLES cycles of debug_unlocked=1)
    - debug_relock=1
    - scan_mode=1
  - debug_unlocked is a registered output, equal to (state==UNLOCKED).
- LOCKOUT:
  - Absorbing state; only resetn exits.
  - key_ready=0 and debug_unlocked=0.
- scan_mode=1 in WAIT_K0 or WAIT_K1:
  - Abort to IDLE.
  - No attempt_done, fail_count unchanged.
- Simultaneous events:
  - debug_relock and expiry together -> single relock to IDLE.
  - scan_mode has priority over any same-cycle key transfer: the transfer is not accepted because key_ready is already 0 combinationally.
- Reset mid-operation: any state returns to the reset values immediately, asynchronously. lockout is cleared only by resetn.

Test Plan:
- Reset then debug_req; send A5C3, then 3C5A with key_valid held -> key_ready is high in both wait cycles; the cycle after the second transfer shows debug_unlocked=1, attempt_done=1, attempt_pass=1.
- UNLOCK_CYCLES=16, correct unlock -> debug_unlocked stays high exactly 16 cycles then drops to 0 with no stimulus; a second debug_req can unlock again.
- Three attempts with words 0000/3C5A -> each attempt takes both words, fail_count goes 1,2,3; after the third, lockout=1 and key_ready stays 0 after a further debug_req with correct keys; only resetn clears it.
- KEY_TIMEOUT=8: send A5C3, then idle for 8 cycles -> attempt_done with attempt_pass=0, fail_count=1, state IDLE.
- During an unlocked session, raise scan_mode for 1 cycle -> debug_unlocked=0 next cycle. Also raise scan_mode in WAIT_K1 with key_valid=1 -> no transfer, no attempt_done, fail_count unchanged.
- Assert debug_relock and deassert resetn mid-session (asynchronously, between edges) -> debug_unlocked falls without waiting for a clock; after reset, fail_count=0 and lockout=0.
